multi_ch_measure_ctl: RTL and testbench
=======================================

# multi_ch_measure_ctl

Parametrised successor to the single-channel threshold/delay controller. It sweeps a shared delay-line code across a programmable window. At each delay step, for each of `N_CH` comparator channels in turn, it finds the threshold crossing point, by either successive-approximation (binary) search or linear stepping. Each resolved point goes out on a valid/ready stream toward the measurement FIFO. The block sits between the per-channel comparators, the shared strobe generator, the threshold DAC and the delay line.

## Interface
- `N_CH`, 4: number of comparator channels (≥1).
- `TH_W`, 16: threshold / DAC code width.
- `DC_W`, 10: delay-code width.
- `CH_W`, `$clog2(N_CH)` (min 1): channel index width.

- `clk_i` in 1: clock.
- `arst_i` in 1: one clock; reset is asynchronous and active-high.
- `run_i` in 1: level; 1 starts or continues the sweep, 0 aborts.
- `mode_i` in 1: 0 = linear search, 1 = binary search. Sampled on leaving IDLE.
- `d_start_i`, `d_stop_i` in `DC_W`: inclusive delay window. Sampled on leaving IDLE.
- `d_code_delta_i` in `DC_W`: delay step, ≥1. A value of 0 is treated as 1.
- `threshold_delta_i` in `TH_W`: linear step, ≥1. A value of 0 is treated as 1.
- `cmp_out_i` in `N_CH`: comparator outputs; 1 = signal ≥ threshold.
- `stb_req_o` out 1: strobe request pulse.
- `stb_valid_i` in 1: strobe done; `cmp_out_i` is valid this cycle.
- `threshold_o` out `TH_W`: DAC code.
- `threshold_ch_o` out `CH_W`: DAC channel address.
- `threshold_wre_o` out 1: DAC write pulse.
- `threshold_rdy_i` in 1: DAC settled.
- `d_code_o` out `DC_W`: delay-line code.
- `point_valid_o` out 1: point available.
- `point_ready_i` in 1: point accepted.
- `point_ch_o` out `CH_W`, `point_t_o` out `DC_W`, `point_v_o` out `TH_W`, `point_sat_o` out 1: point payload.
- `busy_o` out 1: not IDLE.
- `done_o` out 1: one-cycle pulse when the sweep completes.

## Operation
- FSM states: IDLE, SET_THR, WAIT_THR, REQ_STB, WAIT_STB, EVAL, EMIT, NEXT.
- IDLE → SET_THR when `run_i`=1:
  - latch mode and window;
  - `d_code_o` ← `d_start_i`, `ch` ← 0;
  - initialise the search.
- Search initialisation:
  - Binary mode: `threshold` ← `1<<(TH_W-1)`, `bit` ← `TH_W-1`.
  - Linear mode: `threshold` ← 0, `last_hit` ← 0, `hit_seen` ← 0.
- SET_THR → WAIT_THR. WAIT_THR → REQ_STB when `threshold_rdy_i`. REQ_STB → WAIT_STB. WAIT_STB → EVAL when `stb_valid_i`; `cmp_out_i[ch]` is registered that cycle.
- EVAL, binary mode:
  - if cmp=0, clear `threshold[bit]`;
  - if `bit`=0 → EMIT;
  - else set `threshold[bit-1]`, decrement `bit`, → SET_THR.
  - Result is the largest code with cmp=1.
  - `sat` = (result all-ones) or (result 0 and final cmp 0).
- EVAL, linear mode:
  - if cmp=1, `last_hit` ← `threshold`, `hit_seen` ← 1;
  - if cmp=0 → EMIT with value `last_hit`, `sat` = !`hit_seen`;
  - else if `threshold + threshold_delta_i` overflows `TH_W` (compute at `TH_W+1` bits) → EMIT with value `threshold`, `sat`=1;
  - else add `threshold_delta_i` → SET_THR.
- EMIT:
  - `point_valid_o`=1 with payload {`ch`, `d_code_o`, value, `sat`};
  - → NEXT on the cycle `point_valid_o & point_ready_i`;
  - payload is held stable while waiting.
- NEXT:
  - if `ch` < `N_CH-1`: `ch`++, re-initialise the search, → SET_THR;
  - else `ch` ← 0, then:
    - if `d_code_o + d_code_delta_i` > `d_stop_i` or overflows `DC_W` (compute at `DC_W+1` bits): → IDLE, `done_o` pulse;
    - else `d_code_o` += delta, re-initialise, → SET_THR.
- `run_i`=0 in any state → IDLE on the next edge:
  - `point_valid_o` drops;
  - no `done_o`;
  - `d_code_o` and `threshold_o` hold their last values.
- `d_start_i` > `d_stop_i`: exactly one delay step (`d_start_i`) is measured, then the sweep completes.

## Timing
- All outputs are registered.
- Reset values: `stb_req_o`=0, `threshold_o`=0, `threshold_ch_o`=0, `threshold_wre_o`=0, `d_code_o`=0, `point_valid_o`=0, point payload=0, `busy_o`=0, `done_o`=0. FSM=IDLE.
- `threshold_wre_o` is high exactly one cycle, the cycle after SET_THR. `threshold_o` and `threshold_ch_o` are stable from that cycle until the next SET_THR.
- `stb_req_o` is high exactly one cycle, the cycle after REQ_STB.
- `threshold_rdy_i` and `stb_valid_i` are level-checked only in their wait states; asserting them early is harmless.
- Binary mode: exactly `TH_W` DAC writes and `TH_W` strobes per point.
- Zero-wait latency per iteration (DAC ready and strobe valid the cycle after request) is 5 cycles: SET_THR, WAIT_THR, REQ_STB, WAIT_STB, EVAL.
- `point_valid_o` rises the cycle after EVAL decides. `done_o` rises the cycle after the final NEXT, coincident with `busy_o` falling.

## Test plan
- Binary, `N_CH`=2, `TH_W`=8, ch0 level 100, ch1 level 3, window 0..0, ready held 1. Required: exactly two points, ch0 v=100 and ch1 v=3, both sat=0; 8 `threshold_wre_o` pulses each; one `done_o` pulse.
- Linear, delta=10, level 35. Required: DAC writes 0, 10, 20, 30, 40; point v=30, sat=0.
- Linear, level above full scale, `TH_W`=8, delta=100. Required: writes 0, 100, 200; point v=200, sat=1. Binary mode on the same level: v=255, sat=1.
- Window 5..12, step 3, `N_CH`=1. Required: points at t=5, 8, 11, then `done_o`. Repeat with `d_stop_i`=1023, `d_start_i`=1020, step 4 (DC overflow): one point only.
- Hold `point_ready_i`=0 for 20 cycles during EMIT. Required: payload stable, no new DAC write or strobe; on acceptance the next channel starts.
- Drop `run_i` in WAIT_STB, and assert `arst_i` mid-sweep. Required: IDLE next cycle, no `done_o`; after reset, all outputs at their reset values immediately (asynchronous).

Source files
------------

// File: rtl/multi_ch_measure_ctl_if.sv
// -----------------------------------------------------------------------------
// multi_ch_measure_ctl_if
//   Bundles the sweep configuration, the DAC / strobe / comparator handshakes
//   and the measurement-point stream of multi_ch_measure_ctl.
//
//   master : the controller (drives DAC, strobe, delay code, point stream)
//   slave  : the surrounding analog front end and measurement FIFO
// -----------------------------------------------------------------------------
interface multi_ch_measure_ctl_if #(
    parameter int N_CH = 4,
    parameter int TH_W = 16,
    parameter int DC_W = 10,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
    // configuration / control
    logic            run_i;
    logic            mode_i;
    logic [DC_W-1:0] d_start_i;
    logic [DC_W-1:0] d_stop_i;
    logic [DC_W-1:0] d_code_delta_i;
    logic [TH_W-1:0] threshold_delta_i;

    // comparators and strobe generator
    logic [N_CH-1:0] cmp_out_i;
    logic            stb_req_o;
    logic            stb_valid_i;

    // threshold DAC
    logic [TH_W-1:0] threshold_o;
    logic [CH_W-1:0] threshold_ch_o;
    logic            threshold_wre_o;
    logic            threshold_rdy_i;

    // delay line
    logic [DC_W-1:0] d_code_o;

    // measurement point stream
    logic            point_valid_o;
    logic            point_ready_i;
    logic [CH_W-1:0] point_ch_o;
    logic [DC_W-1:0] point_t_o;
    logic [TH_W-1:0] point_v_o;
    logic            point_sat_o;

    // status
    logic            busy_o;
    logic            done_o;

    modport master (
        input  run_i, mode_i, d_start_i, d_stop_i, d_code_delta_i, threshold_delta_i,
        input  cmp_out_i, stb_valid_i, threshold_rdy_i, point_ready_i,
        output stb_req_o, threshold_o, threshold_ch_o, threshold_wre_o, d_code_o,
        output point_valid_o, point_ch_o, point_t_o, point_v_o, point_sat_o,
        output busy_o, done_o
    );

    modport slave (
        output run_i, mode_i, d_start_i, d_stop_i, d_code_delta_i, threshold_delta_i,
        output cmp_out_i, stb_valid_i, threshold_rdy_i, point_ready_i,
        input  stb_req_o, threshold_o, threshold_ch_o, threshold_wre_o, d_code_o,
        input  point_valid_o, point_ch_o, point_t_o, point_v_o, point_sat_o,
        input  busy_o, done_o
    );
endinterface

// File: rtl/multi_ch_measure_ctl.sv
// -----------------------------------------------------------------------------
// multi_ch_measure_ctl
//   Sweeps a shared delay-line code over [d_start, d_stop] and, at every delay
//   step, resolves the threshold crossing of each comparator channel in turn,
//   either by successive approximation (mode 1) or linear stepping (mode 0).
//   Each resolved point is offered on a valid/ready stream.
//
// Ports
//   clk_i   : clock
//   arst_i  : asynchronous active-high reset
//   bus     : multi_ch_measure_ctl_if.master (config, DAC, strobe,
//             comparator, delay code, point stream, busy/done)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for run; outputs hold their last values
// SET_THR  | load working threshold into the DAC registers, pulse write
// WAIT_THR | wait for DAC settled
// REQ_STB  | pulse strobe request
// WAIT_STB | wait for strobe done, capture the current channel's comparator
// EVAL     | advance the search or resolve the point
// EMIT     | offer the point until accepted
// NEXT     | next channel, or next delay step, or finish the sweep
// -----------------------------------------------------------------------------
module multi_ch_measure_ctl #(
    parameter int N_CH = 4,
    parameter int TH_W = 16,
    parameter int DC_W = 10,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    multi_ch_measure_ctl_if.master bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SET_THR  = 3'd1;
    localparam logic [2:0] S_WAIT_THR = 3'd2;
    localparam logic [2:0] S_REQ_STB  = 3'd3;
    localparam logic [2:0] S_WAIT_STB = 3'd4;
    localparam logic [2:0] S_EVAL     = 3'd5;
    localparam logic [2:0] S_EMIT     = 3'd6;
    localparam logic [2:0] S_NEXT     = 3'd7;

    localparam int              BIT_W   = (TH_W > 1) ? $clog2(TH_W) : 1;
    localparam logic [TH_W-1:0] THR_MID = TH_W'(1) << (TH_W - 1);
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(TH_W - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);

    logic [2:0]       state;
    logic             mode_q;
    logic [DC_W-1:0]  d_stop_q;
    logic [CH_W-1:0]  ch;
    logic [TH_W-1:0]  thr;          // working threshold of the running search
    logic [BIT_W-1:0] bit_idx;
    logic [TH_W-1:0]  last_hit;
    logic             hit_seen;
    logic             cmp_q;

    logic             stb_req;
    logic [TH_W-1:0]  threshold;
    logic [CH_W-1:0]  threshold_ch;
    logic             threshold_wre;
    logic [DC_W-1:0]  d_code;
    logic             point_valid;
    logic [CH_W-1:0]  point_ch;
    logic [DC_W-1:0]  point_t;
    logic [TH_W-1:0]  point_v;
    logic             point_sat;
    logic             busy;
    logic             done;

    logic [TH_W-1:0]  th_delta;
    logic [DC_W-1:0]  dc_delta;
    logic [TH_W:0]    lin_sum;
    logic [DC_W:0]    dc_sum;
    logic [TH_W-1:0]  bin_res;
    logic [TH_W-1:0]  bin_next;
    logic             emit_now;
    logic [TH_W-1:0]  emit_v;
    logic             emit_sat;

    // Step sizes of zero would stall the sweep, so they are promoted to one.
    // Sums are one bit wider so overflow shows up in the MSB.
    always_comb begin
        th_delta = (bus.threshold_delta_i == '0) ? TH_W'(1) : bus.threshold_delta_i;
        dc_delta = (bus.d_code_delta_i == '0) ? DC_W'(1) : bus.d_code_delta_i;
        lin_sum  = {1'b0, thr} + {1'b0, th_delta};
        dc_sum   = {1'b0, d_code} + {1'b0, dc_delta};

        bin_res = thr;
        if (!cmp_q) begin
            bin_res[bit_idx] = 1'b0;
        end
        bin_next = bin_res | (TH_W'(1) << (bit_idx - BIT_W'(1)));
    end

    always_comb begin
        emit_now = 1'b0;
        emit_v   = bin_res;
        emit_sat = (&bin_res) || ((bin_res == '0) && !cmp_q);
        if (mode_q) begin
            emit_now = (bit_idx == '0);
        end else if (!cmp_q) begin
            emit_now = 1'b1;
            emit_v   = last_hit;
            emit_sat = !hit_seen;
        end else if (lin_sum[TH_W]) begin
            emit_now = 1'b1;
            emit_v   = thr;
            emit_sat = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state         <= S_IDLE;
            mode_q        <= 1'b0;
            d_stop_q      <= '0;
            ch            <= '0;
            thr           <= '0;
            bit_idx       <= '0;
            last_hit      <= '0;
            hit_seen      <= 1'b0;
            cmp_q         <= 1'b0;
            stb_req       <= 1'b0;
            threshold     <= '0;
            threshold_ch  <= '0;
            threshold_wre <= 1'b0;
            d_code        <= '0;
            point_valid   <= 1'b0;
            point_ch      <= '0;
            point_t       <= '0;
            point_v       <= '0;
            point_sat     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            threshold_wre <= 1'b0;
            stb_req       <= 1'b0;
            done          <= 1'b0;

            if ((state != S_IDLE) && !bus.run_i) begin
                // abort: DAC and delay codes deliberately keep their values
                state       <= S_IDLE;
                busy        <= 1'b0;
                point_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.run_i) begin
                            mode_q   <= bus.mode_i;
                            d_stop_q <= bus.d_stop_i;
                            d_code   <= bus.d_start_i;
                            ch       <= '0;
                            thr      <= bus.mode_i ? THR_MID : '0;
                            bit_idx  <= BIT_TOP;
                            last_hit <= '0;
                            hit_seen <= 1'b0;
                            busy     <= 1'b1;
                            state    <= S_SET_THR;
                        end
                    end
                    S_SET_THR: begin
                        threshold     <= thr;
                        threshold_ch  <= ch;
                        threshold_wre <= 1'b1;
                        state         <= S_WAIT_THR;
                    end
                    S_WAIT_THR: begin
                        if (bus.threshold_rdy_i) begin
                            state <= S_REQ_STB;
                        end
                    end
                    S_REQ_STB: begin
                        stb_req <= 1'b1;
                        state   <= S_WAIT_STB;
                    end
                    S_WAIT_STB: begin
                        if (bus.stb_valid_i) begin
                            cmp_q <= bus.cmp_out_i[ch];
                            state <= S_EVAL;
                        end
                    end
                    S_EVAL: begin
                        if (!mode_q && cmp_q) begin
                            last_hit <= thr;
                            hit_seen <= 1'b1;
                        end
                        if (emit_now) begin
                            point_valid <= 1'b1;
                            point_ch    <= ch;
                            point_t     <= d_code;
                            point_v     <= emit_v;
                            point_sat   <= emit_sat;
                            state       <= S_EMIT;
                        end else begin
                            if (mode_q) begin
                                thr     <= bin_next;
                                bit_idx <= bit_idx - BIT_W'(1);
                            end else begin
                                thr <= lin_sum[TH_W-1:0];
                            end
                            state <= S_SET_THR;
                        end
                    end
                    S_EMIT: begin
                        if (bus.point_ready_i) begin
                            point_valid <= 1'b0;
                            state       <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        thr      <= mode_q ? THR_MID : '0;
                        bit_idx  <= BIT_TOP;
                        last_hit <= '0;
                        hit_seen <= 1'b0;
                        if (ch != CH_LAST) begin
                            ch    <= ch + CH_W'(1);
                            state <= S_SET_THR;
                        end else begin
                            ch <= '0;
                            if (dc_sum[DC_W] || (dc_sum > {1'b0, d_stop_q})) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                d_code <= dc_sum[DC_W-1:0];
                                state  <= S_SET_THR;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.stb_req_o       = stb_req;
    assign bus.threshold_o     = threshold;
    assign bus.threshold_ch_o  = threshold_ch;
    assign bus.threshold_wre_o = threshold_wre;
    assign bus.d_code_o        = d_code;
    assign bus.point_valid_o   = point_valid;
    assign bus.point_ch_o      = point_ch;
    assign bus.point_t_o       = point_t;
    assign bus.point_v_o       = point_v;
    assign bus.point_sat_o     = point_sat;
    assign bus.busy_o          = busy;
    assign bus.done_o          = done;

endmodule

// File: tb/tb_multi_ch_measure_ctl.sv
// -----------------------------------------------------------------------------
// tb_multi_ch_measure_ctl
//   Drives multi_ch_measure_ctl with behavioural comparators (one level per
//   channel, compared against the last DAC code written for that channel) and
//   checks every emitted point against an arithmetic reference of the search.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multi_ch_measure_ctl;

    localparam int N_CH   = 2;
    localparam int TH_W   = 8;
    localparam int DC_W   = 10;
    localparam int CH_W   = 1;
    localparam int TH_MAX = (1 << TH_W) - 1;
    localparam int DC_MAX = (1 << DC_W) - 1;

    typedef struct {
        int ch;
        int t;
        int v;
        int sat;
        int nwr;
        int wsum;
        int wch;
    } pt_t;

    logic clk_i  = 1'b0;
    logic arst_i = 1'b0;

    always #5 clk_i = ~clk_i;

    multi_ch_measure_ctl_if #(.N_CH(N_CH), .TH_W(TH_W), .DC_W(DC_W), .CH_W(CH_W)) bus ();

    multi_ch_measure_ctl #(.N_CH(N_CH), .TH_W(TH_W), .DC_W(DC_W), .CH_W(CH_W)) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .bus    (bus)
    );

    int  n_checks = 0;
    int  n_errors = 0;

    // stimulus controls (main process only)
    int  level [N_CH];
    bit  zw        = 1'b1;
    bit  block_stb = 1'b0;
    int  stall_req = 0;

    // observation (monitor / responder only)
    int  stall_ack = 0;
    pt_t got_q [$];
    int  dac [N_CH];
    int  wr_cnt, wr_sum, wr_ch;
    int  done_cnt  = 0;
    int  proto_err = 0;
    int  cyc = 0, last_wre_cyc = 0, wre_gap = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference point: binary search gives the largest code not above the
    // level; linear search walks 0, d, 2d, ... until the comparator drops or
    // the next step leaves the code range.
    task automatic model_point(input int lvl, input bit bin, input int thd,
                               output int v, output int sat, output int nwr, output int wsum);
        int d;
        int t;
        d = (thd == 0) ? 1 : thd;
        t = 0;
        if (bin) begin
            v    = (lvl > TH_MAX) ? TH_MAX : lvl;
            sat  = (v == TH_MAX || v == 0) ? 1 : 0;
            nwr  = TH_W;
            wsum = -1;
        end else begin
            nwr = 0; wsum = 0; v = 0; sat = 1;
            while (1) begin
                nwr++;
                wsum += t;
                if (lvl < t)       begin v = t - d; sat = 0; break; end
                if (t + d > TH_MAX) begin v = t;     sat = 1; break; end
                t += d;
            end
        end
    endtask

    // responder: DAC settle, strobe completion, FIFO ready
    initial begin
        bus.threshold_rdy_i = 1'b0;
        bus.stb_valid_i     = 1'b0;
        bus.point_ready_i   = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if ((stall_req != stall_ack) && bus.point_valid_o) begin
                bus.point_ready_i = 1'b0;
                repeat (20) @(posedge clk_i);
                #1;
                stall_ack = stall_req;
            end
            bus.threshold_rdy_i = zw ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            bus.stb_valid_i     = block_stb ? 1'b0 : (zw ? 1'b1 : 1'($urandom_range(0, 2) != 0));
            bus.point_ready_i   = zw ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // monitor + comparator model, sampled on the falling edge
    initial begin
        bit  pv, pr;
        int  pch, pt, pvv, psat;
        pt_t g;
        pv = 0; pr = 0; pch = 0; pt = 0; pvv = 0; psat = 0;
        wr_cnt = 0; wr_sum = 0; wr_ch = 0;
        for (int c = 0; c < N_CH; c++) dac[c] = 0;
        bus.cmp_out_i = '0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!bus.busy_o) begin
                wr_cnt = 0;
                wr_sum = 0;
            end
            if (bus.threshold_wre_o) begin
                dac[bus.threshold_ch_o] = int'(bus.threshold_o);
                wr_cnt++;
                wr_sum += int'(bus.threshold_o);
                wr_ch   = int'(bus.threshold_ch_o);
                wre_gap = cyc - last_wre_cyc;
                last_wre_cyc = cyc;
            end
            for (int c = 0; c < N_CH; c++) bus.cmp_out_i[c] = (level[c] >= dac[c]);
            if (bus.point_valid_o && (bus.threshold_wre_o || bus.stb_req_o)) proto_err++;
            if (bus.point_valid_o && pv && !pr &&
                (pch != int'(bus.point_ch_o) || pt != int'(bus.point_t_o) ||
                 pvv != int'(bus.point_v_o) || psat != int'(bus.point_sat_o))) proto_err++;
            if (bus.done_o) begin
                done_cnt++;
                if (bus.busy_o) proto_err++;
            end
            if (bus.point_valid_o && bus.point_ready_i) begin
                g.ch = int'(bus.point_ch_o); g.t = int'(bus.point_t_o);
                g.v  = int'(bus.point_v_o);  g.sat = int'(bus.point_sat_o);
                g.nwr = wr_cnt; g.wsum = wr_sum; g.wch = wr_ch;
                got_q.push_back(g);
                wr_cnt = 0;
                wr_sum = 0;
            end
            pv = bus.point_valid_o; pr = bus.point_ready_i;
            pch = int'(bus.point_ch_o); pt = int'(bus.point_t_o);
            pvv = int'(bus.point_v_o);  psat = int'(bus.point_sat_o);
        end
    end

    task automatic check_reset(input string p);
        check_eq({p, "_stb_req"},   int'(bus.stb_req_o), 0);
        check_eq({p, "_thr"},       int'(bus.threshold_o), 0);
        check_eq({p, "_thr_ch"},    int'(bus.threshold_ch_o), 0);
        check_eq({p, "_thr_wre"},   int'(bus.threshold_wre_o), 0);
        check_eq({p, "_d_code"},    int'(bus.d_code_o), 0);
        check_eq({p, "_pt_valid"},  int'(bus.point_valid_o), 0);
        check_eq({p, "_pt_ch"},     int'(bus.point_ch_o), 0);
        check_eq({p, "_pt_t"},      int'(bus.point_t_o), 0);
        check_eq({p, "_pt_v"},      int'(bus.point_v_o), 0);
        check_eq({p, "_pt_sat"},    int'(bus.point_sat_o), 0);
        check_eq({p, "_busy"},      int'(bus.busy_o), 0);
        check_eq({p, "_done"},      int'(bus.done_o), 0);
    endtask

    task automatic run_sweep(input string name, input bit bin, input int start,
                             input int stop, input int step, input int thd);
        pt_t exp_q [$];
        pt_t e, g;
        int  ts [$];
        int  t, st, gbase, dbase, pbase, waited, n;
        st = (step == 0) ? 1 : step;
        t  = start;
        while (1) begin
            ts.push_back(t);
            if (t + st > stop || t + st > DC_MAX) break;
            t += st;
        end
        foreach (ts[i]) begin
            for (int c = 0; c < N_CH; c++) begin
                e.ch = c; e.t = ts[i]; e.wch = c;
                model_point(level[c], bin, thd, e.v, e.sat, e.nwr, e.wsum);
                exp_q.push_back(e);
            end
        end
        gbase = got_q.size(); dbase = done_cnt; pbase = proto_err;
        bus.mode_i            = bin;
        bus.d_start_i         = DC_W'(start);
        bus.d_stop_i          = DC_W'(stop);
        bus.d_code_delta_i    = DC_W'(step);
        bus.threshold_delta_i = TH_W'(thd);
        @(negedge clk_i);
        bus.run_i = 1'b1;
        waited = 0;
        while (!bus.done_o && waited < 20000) begin
            @(negedge clk_i);
            waited++;
        end
        bus.run_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq({name, "_done"}, done_cnt - dbase, 1);
        n = got_q.size() - gbase;
        check_eq({name, "_npts"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            g = got_q[gbase + i];
            e = exp_q[i];
            check_eq($sformatf("%s_p%0d_ch", name, i),  g.ch,  e.ch);
            check_eq($sformatf("%s_p%0d_t", name, i),   g.t,   e.t);
            check_eq($sformatf("%s_p%0d_v", name, i),   g.v,   e.v);
            check_eq($sformatf("%s_p%0d_sat", name, i), g.sat, e.sat);
            check_eq($sformatf("%s_p%0d_nwr", name, i), g.nwr, e.nwr);
            check_eq($sformatf("%s_p%0d_wch", name, i), g.wch, e.wch);
            if (e.wsum >= 0) check_eq($sformatf("%s_p%0d_wsum", name, i), g.wsum, e.wsum);
        end
        check_eq({name, "_proto"}, proto_err - pbase, 0);
    endtask

    initial begin
        int st, sp, dbase, waited, dc_hold, th_hold;
        bus.run_i = 1'b0; bus.mode_i = 1'b0;
        bus.d_start_i = '0; bus.d_stop_i = '0;
        bus.d_code_delta_i = '0; bus.threshold_delta_i = '0;
        for (int c = 0; c < N_CH; c++) level[c] = 0;

        #2 arst_i = 1'b1;
        #20;
        check_reset("rst");
        @(negedge clk_i);
        arst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // binary, two channels, single delay step, zero-wait handshakes
        zw = 1; level[0] = 100; level[1] = 3;
        run_sweep("bin_basic", 1'b1, 0, 0, 1, 1);
        check_eq("iter_latency", wre_gap, 5);

        // linear delta 10
        level[0] = 35; level[1] = 200;
        run_sweep("lin_d10", 1'b0, 0, 0, 1, 10);

        // above full scale, both modes
        level[0] = 300; level[1] = 300;
        run_sweep("lin_full", 1'b0, 0, 0, 1, 100);
        run_sweep("bin_full", 1'b1, 0, 0, 1, 100);

        // zero level in binary saturates low
        level[0] = 0; level[1] = 255;
        run_sweep("bin_edge", 1'b1, 0, 0, 1, 1);

        // delay windows
        level[0] = 77; level[1] = 140;
        run_sweep("win_5_12", 1'b1, 5, 12, 3, 1);
        run_sweep("win_ovf", 1'b1, 1020, 1023, 4, 1);
        run_sweep("win_rev", 1'b0, 9, 4, 2, 40);

        // zero step sizes behave as one
        level[0] = 3; level[1] = 5;
        run_sweep("zero_steps", 1'b0, 2, 4, 0, 0);

        // back-pressure on the point stream
        zw = 0; level[0] = 61; level[1] = 190;
        stall_req++;
        run_sweep("stall", 1'b1, 0, 0, 1, 1);
        check_eq("stall_taken", stall_ack, stall_req);

        // randomized sweeps
        for (int k = 0; k < 6; k++) begin
            zw = 1'($urandom_range(0, 1));
            for (int c = 0; c < N_CH; c++) level[c] = $urandom_range(0, 300);
            st = $urandom_range(0, DC_MAX);
            sp = ($urandom_range(0, 3) == 0) ? st - $urandom_range(1, 5) : st + $urandom_range(0, 8);
            if (sp < 0) sp = 0;
            if (sp > DC_MAX) sp = DC_MAX;
            run_sweep($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), st, sp,
                      $urandom_range(0, 5), $urandom_range(16, 120));
        end

        // abort while waiting for the strobe
        zw = 1; block_stb = 1; level[0] = 50; level[1] = 50;
        dbase = done_cnt;
        bus.mode_i = 1'b1; bus.d_start_i = DC_W'(3); bus.d_stop_i = DC_W'(9);
        bus.d_code_delta_i = DC_W'(1);
        @(negedge clk_i);
        bus.run_i = 1'b1;
        waited = 0;
        while (!bus.stb_req_o && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
        check_eq("abort_stb_seen", int'(bus.stb_req_o), 1);
        dc_hold = int'(bus.d_code_o);
        th_hold = int'(bus.threshold_o);
        check_eq("abort_d_code", dc_hold, 3);
        check_eq("abort_thr", th_hold, 128);
        bus.run_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_eq("abort_busy", int'(bus.busy_o), 0);
        repeat (5) @(negedge clk_i);
        check_eq("abort_no_done", done_cnt - dbase, 0);
        check_eq("abort_d_hold", int'(bus.d_code_o), dc_hold);
        check_eq("abort_thr_hold", int'(bus.threshold_o), th_hold);
        check_eq("abort_valid", int'(bus.point_valid_o), 0);
        block_stb = 0;

        // asynchronous reset in the middle of a sweep
        dbase = done_cnt;
        bus.d_start_i = DC_W'(7); bus.d_stop_i = DC_W'(20);
        @(negedge clk_i);
        bus.run_i = 1'b1;
        repeat (30) @(negedge clk_i);
        check_eq("mid_busy", int'(bus.busy_o), 1);
        #2;
        bus.run_i = 1'b0;
        arst_i = 1'b1;
        #1;
        check_reset("arst_mid");
        @(negedge clk_i);
        arst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("arst_no_done", done_cnt - dbase, 0);
        check_eq("arst_idle", int'(bus.busy_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
